// File: rtl/ifu_fetch_way1.sv
// Way-1 instruction fetch unit: issues one memory request per accepted PC and
// buffers the in-order responses for decode, dropping responses owed to flushed fetches.
module ifu_fetch_way1 #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [DATA_W-1:0] inst_data_o,
  input  logic              inst_ready_i,
  output logic              protocol_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [CW-1:0]     pend_q, pend_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              perr_q, perr_d;

  logic [CW:0] credit_sum;
  logic        credit_ok;
  logic        alloc;
  logic        pop;
  logic        fill_hit;

  // Credit covers both live entries and responses still owed to killed requests.
  assign credit_sum = {1'b0, occ_q} + {1'b0, drop_q};
  assign credit_ok  = credit_sum < DEPTH_C;

  assign imem_req_o  = pc_valid_i & credit_ok & ~flush_i;
  assign imem_addr_o = pc_addr_i;
  assign pc_ready_o  = imem_req_o & imem_gnt_i;

  assign inst_valid_o   = filled_q[rd_ptr_q];
  assign inst_addr_o    = addr_q[rd_ptr_q];
  assign inst_data_o    = data_q[rd_ptr_q];
  assign protocol_err_o = perr_q;

  assign alloc = pc_ready_o;
  assign pop   = inst_valid_o & inst_ready_i;

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    filled_d   = filled_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    perr_d     = perr_q;
    fill_hit   = 1'b0;

    if (flush_i) begin
      filled_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      pend_d     = '0;
      // A response landing in the flush cycle is charged against the killed fetches.
      if (imem_rvalid_i) begin
        if ((drop_q != '0) || (pend_q != '0)) begin
          drop_d = drop_q + pend_q - CW'(1);
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        drop_d = drop_q + pend_q;
      end
    end else begin
      if (pop) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PW'(1);
      end
      if (alloc) begin
        addr_d[wr_ptr_q]   = pc_addr_i;
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (imem_rvalid_i) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (pend_q != '0) begin
          fill_hit             = 1'b1;
          data_d[fill_ptr_q]   = imem_rdata_i;
          filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d           = fill_ptr_q + PW'(1);
        end else begin
          perr_d = 1'b1;
        end
      end
      occ_d  = occ_q + CW'(alloc) - CW'(pop);
      pend_d = pend_q + CW'(alloc) - CW'(fill_hit);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          addr_q[gi] <= '0;
          data_q[gi] <= '0;
        end else begin
          addr_q[gi] <= addr_d[gi];
          data_q[gi] <= data_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filled_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      perr_q     <= 1'b0;
    end else begin
      filled_q   <= filled_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      perr_q     <= perr_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_way1.sv
// Directed vector bench for ifu_fetch_way1: one table row per clock cycle,
// outputs compared just after inputs settle, before the next rising edge.
module tb_ifu_fetch_way1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_valid_i;
  logic [31:0] pc_addr_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_o;
  logic        inst_ready_i;
  logic        protocol_err_o;

  ifu_fetch_way1 #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_valid_i     (pc_valid_i),
    .pc_addr_i      (pc_addr_i),
    .pc_ready_o     (pc_ready_o),
    .flush_i        (flush_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_addr_o    (inst_addr_o),
    .inst_data_o    (inst_data_o),
    .inst_ready_i   (inst_ready_i),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pa;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        fl;
    logic        e_prdy;
    logic        e_req;
    logic        e_val;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic [31:0] pa, input logic gnt, input logic rv,
                     input logic [31:0] rd, input logic rdy, input logic fl,
                     input logic e_prdy, input logic e_req, input logic e_val,
                     input logic [31:0] e_addr, input logic [31:0] e_data, input logic e_perr);
    vec_t v;
    v.pv = pv; v.pa = pa; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy; v.fl = fl;
    v.e_prdy = e_prdy; v.e_req = e_req; v.e_val = e_val;
    v.e_addr = e_addr; v.e_data = e_data; v.e_perr = e_perr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pv, input logic [31:0] pa, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic fl);
    pc_valid_i    = pv;
    pc_addr_i     = pa;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    inst_ready_i  = rdy;
    flush_i       = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //   pv  pa     gnt rv  rdata  rdy fl  | prdy req val addr   data   perr
    // streaming
    add(1, 32'h04, 1, 0, 32'h00, 1, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h0C, 1, 1, 32'hD0, 1, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h14, 1, 1, 32'hD1, 1, 0,   1, 1, 1, 32'h04, 32'hD0, 0);
    add(0, 32'h00, 1, 1, 32'hD2, 1, 0,   0, 0, 1, 32'h0C, 32'hD1, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h14, 32'hD2, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    // backpressure: six PCs offered, four accepted, head held
    add(1, 32'h04, 1, 0, 32'h00, 0, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h08, 1, 1, 32'hA0, 0, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h0C, 1, 1, 32'hA1, 0, 0,   1, 1, 1, 32'h04, 32'hA0, 0);
    add(1, 32'h10, 1, 0, 32'h00, 0, 0,   1, 1, 1, 32'h04, 32'hA0, 0);
    add(1, 32'h14, 1, 1, 32'hA2, 0, 0,   0, 0, 1, 32'h04, 32'hA0, 0);
    add(1, 32'h18, 1, 1, 32'hA3, 0, 0,   0, 0, 1, 32'h04, 32'hA0, 0);
    add(1, 32'h18, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h04, 32'hA0, 0);
    add(1, 32'h18, 1, 0, 32'h00, 1, 0,   1, 1, 1, 32'h08, 32'hA1, 0);
    add(0, 32'h00, 1, 1, 32'hA4, 1, 0,   0, 0, 1, 32'h0C, 32'hA2, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h10, 32'hA3, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h18, 32'hA4, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    // grant stall for three cycles
    add(1, 32'h40, 0, 0, 32'h00, 1, 0,   0, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h40, 0, 0, 32'h00, 1, 0,   0, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h40, 0, 0, 32'h00, 1, 0,   0, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h40, 1, 0, 32'h00, 1, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 1, 32'hB0, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h40, 32'hB0, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    // flush with one filled and two in flight
    add(1, 32'h50, 1, 0, 32'h00, 0, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h54, 1, 1, 32'hC0, 0, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(1, 32'h58, 1, 0, 32'h00, 0, 0,   1, 1, 1, 32'h50, 32'hC0, 0);
    add(1, 32'h100,1, 0, 32'h00, 0, 1,   0, 0, 1, 32'h50, 32'hC0, 0);
    add(1, 32'h100,1, 1, 32'hE0, 0, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 1, 32'hE1, 0, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 1, 32'hF0, 0, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h100,32'hF0, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    // flush coincident with the only outstanding response
    add(1, 32'h200,1, 0, 32'h00, 1, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 1, 32'h77, 1, 1,   0, 0, 0, 32'h0,  32'h0,  0);
    add(1, 32'h300,1, 0, 32'h00, 1, 0,   1, 1, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 1, 32'h33, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 1, 32'h300,32'h33, 0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    // spurious response with nothing outstanding
    add(0, 32'h00, 1, 1, 32'h99, 1, 0,   0, 0, 0, 32'h0,  32'h0,  0);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  1);
    add(0, 32'h00, 1, 0, 32'h00, 1, 0,   0, 0, 0, 32'h0,  32'h0,  1);

    #1;
    chk("reset_inst_valid", 32'(inst_valid_o), 32'h0);
    chk("reset_inst_addr", inst_addr_o, 32'h0);
    chk("reset_inst_data", inst_data_o, 32'h0);
    chk("reset_perr", 32'(protocol_err_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].pa, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdy, vecs[i].fl);
      #1;
      $display("vec %0d: pv=%0b pa=%0h fl=%0b rv=%0b -> prdy=%0b req=%0b val=%0b addr=%0h data=%0h perr=%0b",
               i, vecs[i].pv, vecs[i].pa, vecs[i].fl, vecs[i].rv, pc_ready_o, imem_req_o,
               inst_valid_o, inst_addr_o, inst_data_o, protocol_err_o);
      chk($sformatf("v%0d_pc_ready", i), 32'(pc_ready_o), 32'(vecs[i].e_prdy));
      chk($sformatf("v%0d_imem_req", i), 32'(imem_req_o), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_imem_addr", i), imem_addr_o, vecs[i].pa);
      chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid_o), 32'(vecs[i].e_val));
      chk($sformatf("v%0d_perr", i), 32'(protocol_err_o), 32'(vecs[i].e_perr));
      if (vecs[i].e_val) begin
        chk($sformatf("v%0d_inst_addr", i), inst_addr_o, vecs[i].e_addr);
        chk($sformatf("v%0d_inst_data", i), inst_data_o, vecs[i].e_data);
      end
    end

    // asynchronous reset while an instruction is presented and the error flag is set
    @(negedge clk);
    drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("ar_pc_ready", 32'(pc_ready_o), 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    $display("async reset pre: val=%0b addr=%0h data=%0h perr=%0b",
             inst_valid_o, inst_addr_o, inst_data_o, protocol_err_o);
    chk("ar_pre_valid", 32'(inst_valid_o), 32'h1);
    chk("ar_pre_addr", inst_addr_o, 32'h400);
    chk("ar_pre_data", inst_data_o, 32'h55);
    chk("ar_pre_perr", 32'(protocol_err_o), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset: val=%0b addr=%0h data=%0h perr=%0b",
             inst_valid_o, inst_addr_o, inst_data_o, protocol_err_o);
    chk("ar_valid", 32'(inst_valid_o), 32'h0);
    chk("ar_addr", inst_addr_o, 32'h0);
    chk("ar_data", inst_data_o, 32'h0);
    chk("ar_perr", 32'(protocol_err_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("post_reset_pc_ready", 32'(pc_ready_o), 32'h1);
    chk("post_reset_valid", 32'(inst_valid_o), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h66, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("post_reset_addr", inst_addr_o, 32'h500);
    chk("post_reset_data", inst_data_o, 32'h66);
    chk("post_reset_perr", 32'(protocol_err_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
